// File: rtl/sync_fifo_pf.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a choice of registered or fall-through read data.
module sync_fifo_pf #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    input  logic                          err_clr,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

    // Handshake: wr_en/rd_en are requests sampled at every rising edge. A write
    // is taken only when !full and a read only when !empty, judged on the flags
    // as they stand before the edge; a refused request is dropped (never queued)
    // and only leaves its mark on the sticky error flags.

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [FIFO_WIDTH-1:0] dout_q,   dout_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;

    logic                  wr_accept;
    logic                  rd_accept;

    always_comb begin
        wr_accept = wr_en && !full;
        rd_accept = rd_en && !empty;

        wr_ptr_d = wr_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        dout_d = dout_q;
        if (rd_accept) begin
            dout_d = mem_q[rd_ptr_q];
        end

        // A fresh error in the same cycle as err_clr keeps the flag set.
        ovf_d = (ovf_q && !err_clr) || (wr_en && full);
        udf_d = (udf_q && !err_clr) || (rd_en && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign data_out = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;

endmodule
